// File: rtl/kf8253_bus_sequencer.sv
// Host-side bus sequencer for one 8253 counter channel: turns a 16-bit command into
// control-word/count-byte write strobes or read pulses and reassembles read bytes.
module kf8253_bus_sequencer #(
    parameter int CHANNEL           = 2,
    parameter int WRITE_GAP         = 1,
    parameter int READ_PULSE_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [1:0]  cmd_rw,
    input  logic [2:0]  cmd_mode,
    input  logic        cmd_bcd,
    input  logic [15:0] cmd_count,
    output logic [7:0]  internal_data_bus,
    output logic        write_control,
    output logic        write_counter,
    output logic        read_counter,
    input  logic [7:0]  read_counter_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_error
);

    // state | meaning
    // IDLE  | waiting for a command, cmd_ready high
    // CTRL  | write_control strobe (control or latch word)
    // WGAP  | idle cycles after a write strobe, bus held
    // WBYTE | write_counter strobe with one count byte
    // RSTB  | read_counter held high, byte captured on last cycle
    // RREL  | read_counter low for one cycle between/after pulses
    // DONE  | rsp_valid pulse
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CTRL  = 3'd1;
    localparam logic [2:0] WGAP  = 3'd2;
    localparam logic [2:0] WBYTE = 3'd3;
    localparam logic [2:0] RSTB  = 3'd4;
    localparam logic [2:0] RREL  = 3'd5;
    localparam logic [2:0] DONE  = 3'd6;

    localparam logic [1:0] OP_PROG  = 2'b00;
    localparam logic [1:0] OP_LATCH = 2'b01;
    localparam logic [1:0] OP_LIVE  = 2'b10;

    localparam int GW = $clog2(WRITE_GAP + 1);
    localparam int PW = $clog2(READ_PULSE_CYCLES + 1);
    localparam logic [1:0]    CH        = 2'(CHANNEL);
    localparam logic [GW-1:0] GAP_LOAD  = GW'(WRITE_GAP);
    localparam logic [PW-1:0] PULSE_LOAD = PW'(READ_PULSE_CYCLES);

    logic [2:0]    state;
    logic [2:0]    state_nx;
    logic [1:0]    op_q;
    logic [1:0]    rw_q;
    logic [15:0]   count_q;
    logic [1:0]    bytes_left;
    logic [GW-1:0] gap_cnt;
    logic [PW-1:0] pulse_cnt;
    logic [7:0]    rd_lo;
    logic [7:0]    rd_hi;

    logic accept;
    logic cmd_err;
    logic gap_last;
    logic pulse_last;
    logic hi_byte;

    assign cmd_ready  = (state == IDLE);
    assign accept     = cmd_valid && cmd_ready;
    assign cmd_err    = (cmd_op == 2'b11) || (cmd_rw == 2'b00);
    assign gap_last   = (gap_cnt == GW'(1));
    assign pulse_last = (pulse_cnt == PW'(1));
    // RL=10 only ever moves the MSB; RL=11 moves the MSB as its second byte
    assign hi_byte    = (rw_q == 2'b10) || ((rw_q == 2'b11) && (bytes_left == 2'd1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_err)
                        state_nx = DONE;
                    else if (cmd_op == OP_LIVE)
                        state_nx = RSTB;
                    else
                        state_nx = CTRL;
                end
            end
            CTRL:  state_nx = WGAP;
            WGAP: begin
                if (gap_last) begin
                    if (op_q == OP_LATCH)
                        state_nx = RSTB;
                    else if (bytes_left != 2'd0)
                        state_nx = WBYTE;
                    else
                        state_nx = DONE;
                end
            end
            WBYTE: state_nx = WGAP;
            RSTB: begin
                if (pulse_last)
                    state_nx = RREL;
            end
            RREL:  state_nx = (bytes_left != 2'd0) ? RSTB : DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            op_q              <= 2'b00;
            rw_q              <= 2'b00;
            count_q           <= 16'h0000;
            bytes_left        <= 2'd0;
            gap_cnt           <= '0;
            pulse_cnt         <= '0;
            rd_lo             <= 8'h00;
            rd_hi             <= 8'h00;
            internal_data_bus <= 8'h00;
            write_control     <= 1'b0;
            write_counter     <= 1'b0;
            read_counter      <= 1'b0;
            rsp_valid         <= 1'b0;
            rsp_data          <= 16'h0000;
            rsp_error         <= 1'b0;
        end else begin
            state         <= state_nx;
            write_control <= (state_nx == CTRL);
            write_counter <= (state_nx == WBYTE);
            read_counter  <= (state_nx == RSTB);
            rsp_valid     <= (state_nx == DONE);

            if (accept) begin
                op_q       <= cmd_op;
                rw_q       <= cmd_rw;
                count_q    <= cmd_count;
                bytes_left <= (cmd_rw == 2'b11) ? 2'd2 : 2'd1;
                rd_lo      <= 8'h00;
                rd_hi      <= 8'h00;
                if (!cmd_err && (cmd_op == OP_PROG))
                    internal_data_bus <= {CH, cmd_rw, cmd_mode, cmd_bcd};
                else if (!cmd_err && (cmd_op == OP_LATCH))
                    internal_data_bus <= {CH, 6'b000000};
            end

            if ((state_nx == WGAP) && (state != WGAP))
                gap_cnt <= GAP_LOAD;
            else if (state == WGAP)
                gap_cnt <= gap_cnt - GW'(1);

            if ((state == WGAP) && (state_nx == WBYTE)) begin
                internal_data_bus <= hi_byte ? count_q[15:8] : count_q[7:0];
                bytes_left        <= bytes_left - 2'd1;
            end

            if ((state_nx == RSTB) && (state != RSTB))
                pulse_cnt <= PULSE_LOAD;
            else if (state == RSTB)
                pulse_cnt <= pulse_cnt - PW'(1);

            if ((state == RSTB) && pulse_last) begin
                if (hi_byte)
                    rd_hi <= read_counter_data;
                else
                    rd_lo <= read_counter_data;
                bytes_left <= bytes_left - 2'd1;
            end

            // only the error path enters DONE straight from the accept cycle
            if (state_nx == DONE) begin
                rsp_error <= accept && cmd_err;
                rsp_data  <= (accept || (op_q == OP_PROG)) ? 16'h0000 : {rd_hi, rd_lo};
            end else begin
                rsp_error <= 1'b0;
                rsp_data  <= 16'h0000;
            end
        end
    end

endmodule

// File: tb/tb_kf8253_bus_sequencer.sv
// Self-checking bench for kf8253_bus_sequencer: table vectors, random commands,
// reset mid-sequence and back-to-back acceptance, against a schedule-level model.
module tb_kf8253_bus_sequencer;

    localparam int         GAP = 1;
    localparam int         RPC = 2;
    localparam logic [1:0] CH  = 2'd2;

    logic        clock;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [1:0]  cmd_rw;
    logic [2:0]  cmd_mode;
    logic        cmd_bcd;
    logic [15:0] cmd_count;
    logic [7:0]  internal_data_bus;
    logic        write_control;
    logic        write_counter;
    logic        read_counter;
    logic [7:0]  read_counter_data;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_error;

    kf8253_bus_sequencer #(
        .CHANNEL(int'(CH)),
        .WRITE_GAP(GAP),
        .READ_PULSE_CYCLES(RPC)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_rw(cmd_rw),
        .cmd_mode(cmd_mode),
        .cmd_bcd(cmd_bcd),
        .cmd_count(cmd_count),
        .internal_data_bus(internal_data_bus),
        .write_control(write_control),
        .write_counter(write_counter),
        .read_counter(read_counter),
        .read_counter_data(read_counter_data),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .rsp_error(rsp_error)
    );

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  rw;
        logic [2:0]  mode;
        logic        bcd;
        logic [15:0] count;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [15:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    int total = 0;
    int bad   = 0;

    logic [7:0] rb[2];
    int rd_idx = 0;
    int hi_cnt = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Counter model: real byte only on the last high cycle of each read pulse.
    always @(posedge clock) begin
        #1;
        if (read_counter) begin
            hi_cnt = hi_cnt + 1;
            read_counter_data = (hi_cnt == RPC) ? rb[rd_idx & 1] : ~rb[rd_idx & 1];
        end else if (hi_cnt != 0) begin
            rd_idx = rd_idx + 1;
            hi_cnt = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int n = (v.rw == 2'b11) ? 2 : 1;
        r.exp_err = (v.op == 2'b11) || (v.rw == 2'b00);
        if (r.exp_err) begin
            r.exp_data = 16'h0000;
            r.exp_lat  = 1;
        end else begin
            case (v.op)
                2'b00:   r.exp_lat = 1 + (1 + GAP) + n * (1 + GAP);
                2'b01:   r.exp_lat = 1 + (1 + GAP) + n * (RPC + 1);
                default: r.exp_lat = 1 + n * (RPC + 1);
            endcase
            if (v.op == 2'b00)      r.exp_data = 16'h0000;
            else if (v.rw == 2'b01) r.exp_data = {8'h00, v.b0};
            else if (v.rw == 2'b10) r.exp_data = {v.b0, 8'h00};
            else                    r.exp_data = {v.b1, v.b0};
        end
        return r;
    endfunction

    task automatic present(input vec_t v);
        cmd_op    = v.op;
        cmd_rw    = v.rw;
        cmd_mode  = v.mode;
        cmd_bcd   = v.bcd;
        cmd_count = v.count;
        cmd_valid = 1'b1;
    endtask

    task automatic run(input vec_t v, input bit has_next, input vec_t nxt, output int waits);
        logic [3:0] exp_sig[64];
        logic [7:0] exp_bus[64];
        bit         bus_chk[64];
        int         t;
        int         n;
        logic [7:0] bv;
        for (int i = 0; i < 64; i++) begin
            exp_sig[i] = 4'b0000;
            exp_bus[i] = 8'h00;
            bus_chk[i] = 1'b0;
        end
        t = 1;
        n = (v.rw == 2'b11) ? 2 : 1;
        if (!((v.op == 2'b11) || (v.rw == 2'b00))) begin
            if (v.op != 2'b10) begin
                bv = (v.op == 2'b00) ? {CH, v.rw, v.mode, v.bcd} : {CH, 6'b000000};
                exp_sig[t][3] = 1'b1;
                for (int g = 0; g <= GAP; g++) begin
                    exp_bus[t + g] = bv;
                    bus_chk[t + g] = 1'b1;
                end
                t += 1 + GAP;
            end
            for (int i = 0; i < n; i++) begin
                if (v.op == 2'b00) begin
                    bv = ((v.rw == 2'b10) || (i == 1)) ? v.count[15:8] : v.count[7:0];
                    exp_sig[t][2] = 1'b1;
                    for (int g = 0; g <= GAP; g++) begin
                        exp_bus[t + g] = bv;
                        bus_chk[t + g] = 1'b1;
                    end
                    t += 1 + GAP;
                end else begin
                    for (int p = 0; p < RPC; p++) exp_sig[t + p][1] = 1'b1;
                    t += RPC + 1;
                end
            end
        end
        exp_sig[v.exp_lat][0] = 1'b1;

        rb[0] = v.b0;
        rb[1] = v.b1;
        rd_idx = 0;
        hi_cnt = 0;
        present(v);
        waits = 0;
        while (!cmd_ready && waits < 20) begin
            @(negedge clock);
            waits++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        if (has_next) begin
            present(nxt);
        end else begin
            cmd_valid = 1'b0;
            cmd_op    = 2'($urandom);
            cmd_rw    = 2'($urandom);
            cmd_mode  = 3'($urandom);
            cmd_bcd   = 1'($urandom);
            cmd_count = 16'($urandom);
        end
        for (int k = 1; (k <= v.exp_lat + 1) && (k < 64); k++) begin
            @(negedge clock);
            chk("strobes", {28'd0, write_control, write_counter, read_counter, rsp_valid},
                {28'd0, exp_sig[k]});
            if (bus_chk[k]) chk("bus", {24'd0, internal_data_bus}, {24'd0, exp_bus[k]});
            if (k == v.exp_lat) begin
                chk("rsp_data", {16'd0, rsp_data}, {16'd0, v.exp_data});
                chk("rsp_error", {31'd0, rsp_error}, {31'd0, v.exp_err});
                chk("ready_in_done", {31'd0, cmd_ready}, 32'd0);
            end
            if (k == v.exp_lat + 1) chk("ready_after", {31'd0, cmd_ready}, 32'd1);
        end
    endtask

    vec_t tbl[11];
    vec_t v;
    vec_t v2;
    vec_t none;
    int   w;
    int   found;

    initial begin
        //         op     rw     mode    bcd   count     b0     b1     data      err   lat
        tbl[0]  = '{2'b00, 2'b11, 3'b010, 1'b0, 16'h1234, 8'h00, 8'h00, 16'h0000, 1'b0, 7};
        tbl[1]  = '{2'b01, 2'b11, 3'b000, 1'b0, 16'h0000, 8'hCD, 8'hAB, 16'hABCD, 1'b0, 9};
        tbl[2]  = '{2'b10, 2'b10, 3'b000, 1'b0, 16'h0000, 8'h5A, 8'h00, 16'h5A00, 1'b0, 4};
        tbl[3]  = '{2'b11, 2'b11, 3'b011, 1'b1, 16'hFFFF, 8'h12, 8'h34, 16'h0000, 1'b1, 1};
        tbl[4]  = '{2'b00, 2'b00, 3'b001, 1'b0, 16'h4321, 8'h00, 8'h00, 16'h0000, 1'b1, 1};
        tbl[5]  = '{2'b00, 2'b01, 3'b101, 1'b1, 16'hBEEF, 8'h00, 8'h00, 16'h0000, 1'b0, 5};
        tbl[6]  = '{2'b00, 2'b10, 3'b100, 1'b0, 16'h7788, 8'h00, 8'h00, 16'h0000, 1'b0, 5};
        tbl[7]  = '{2'b01, 2'b01, 3'b000, 1'b0, 16'h0000, 8'h3C, 8'h99, 16'h003C, 1'b0, 6};
        tbl[8]  = '{2'b10, 2'b11, 3'b000, 1'b0, 16'h0000, 8'h11, 8'h22, 16'h2211, 1'b0, 7};
        tbl[9]  = '{2'b10, 2'b01, 3'b000, 1'b0, 16'h0000, 8'hFF, 8'h77, 16'h00FF, 1'b0, 4};
        tbl[10] = '{2'b01, 2'b10, 3'b000, 1'b0, 16'h0000, 8'h96, 8'h44, 16'h9600, 1'b0, 6};
        none    = '{2'b00, 2'b00, 3'b000, 1'b0, 16'h0000, 8'h00, 8'h00, 16'h0000, 1'b0, 1};

        reset_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = 2'b00;
        cmd_rw = 2'b00;
        cmd_mode = 3'b000;
        cmd_bcd = 1'b0;
        cmd_count = 16'h0000;
        read_counter_data = 8'h00;
        rb[0] = 8'h00;
        rb[1] = 8'h00;

        repeat (3) @(negedge clock);
        chk("reset_outputs",
            {7'd0, write_control, write_counter, read_counter, rsp_valid, rsp_error,
             internal_data_bus, rsp_data}, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("reset_ready", {31'd0, cmd_ready}, 32'd1);

        for (int i = 0; i < 11; i++) run(tbl[i], 1'b0, none, w);

        // reset while write_counter is high: strobes drop asynchronously, no response
        v = tbl[0];
        v.count = 16'hA5C3;
        present(v);
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        found = 0;
        for (int k = 0; k < 10 && found == 0; k++) begin
            @(negedge clock);
            if (write_counter) found = 1;
        end
        chk("reset_found_wcnt", found, 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("reset_async_drop",
            {19'd0, write_control, write_counter, read_counter, rsp_valid, internal_data_bus},
            32'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("post_reset_idle", {30'd0, rsp_valid, cmd_ready}, 32'd1);
        end
        run(tbl[0], 1'b0, none, w);

        // back-to-back with cmd_valid held: second accepted right after rsp_valid
        run(tbl[1], 1'b1, tbl[6], w);
        run(tbl[6], 1'b0, none, w);
        chk("b2b_wait", w, 0);

        for (int i = 0; i < 40; i++) begin
            v.op    = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            v.rw    = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            v.mode  = 3'($urandom);
            v.bcd   = 1'($urandom);
            v.count = 16'($urandom);
            v.b0    = 8'($urandom);
            v.b1    = 8'($urandom);
            v = model(v);
            v2.op    = 2'($urandom_range(0, 2));
            v2.rw    = 2'($urandom_range(1, 3));
            v2.mode  = 3'($urandom);
            v2.bcd   = 1'($urandom);
            v2.count = 16'($urandom);
            v2.b0    = 8'($urandom);
            v2.b1    = 8'($urandom);
            v2 = model(v2);
            if (i % 4 == 0) begin
                run(v, 1'b1, v2, w);
                run(v2, 1'b0, none, w);
                chk("rand_b2b_wait", w, 0);
            end else begin
                run(v, 1'b0, none, w);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
